// File: rtl/mac_learning_port_lookup_pkg.sv
// rtl/mac_learning_port_lookup_pkg.sv - shared constants and table entry type for the MAC learning lookup
// MAC and EtherType constants are in the byte-swapped form they take in tdata.
package mac_learning_port_lookup_pkg;

  localparam logic [47:0] PTP_DST_MAC   = 48'h0E_00_00_C2_80_01;
  localparam logic [15:0] PTP_ETHERTYPE = 16'hF7_88;
  localparam logic [7:0]  PTP_CPU_PORT  = 8'h02;
  localparam logic [7:0]  PORT_ODD_MASK = 8'hAA;

  // Age field is sized for the widest supported AGE_WIDTH; narrower builds leave the top bits zero.
  localparam int MAX_AGE_WIDTH = 8;

  typedef struct packed {
    logic                     valid;
    logic                     is_static;
    logic [MAX_AGE_WIDTH-1:0] age;
    logic [7:0]               port;
    logic [47:0]              mac;
  } mac_entry_t;

endpackage

// File: rtl/mac_table_cam.sv
// rtl/mac_table_cam.sv - MAC table storage with parallel match, lowest-index priority, learning and aging
// Config writes win over learning, and learning wins over the aging decrement on the same entry.
module mac_table_cam
  import mac_learning_port_lookup_pkg::*;
#(
  parameter int NUM_ENTRIES     = 32,
  parameter int AGE_WIDTH       = 4,
  parameter int AGE_TICK_CYCLES = 1000000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [47:0]                    lookup_dst_i,
  output logic                           dst_hit_o,
  output logic [7:0]                     dst_port_o,
  input  logic                           learn_en_i,
  input  logic [47:0]                    learn_mac_i,
  input  logic [7:0]                     learn_port_i,
  input  logic                           cfg_wr_en_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_index_i,
  input  logic [47:0]                    cfg_mac_i,
  input  logic [7:0]                     cfg_port_i,
  input  logic                           cfg_static_i,
  input  logic                           cfg_valid_i,
  output logic                           learn_drop_o,
  output logic                           table_full_o
);

  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int TICK_W = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0]        TICK_LAST = TICK_W'(AGE_TICK_CYCLES - 1);
  localparam logic [MAX_AGE_WIDTH-1:0] AGE_FULL  = MAX_AGE_WIDTH'((1 << AGE_WIDTH) - 1);

  mac_entry_t entry_q [NUM_ENTRIES];
  mac_entry_t entry_d [NUM_ENTRIES];

  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic                   table_full_q;
  logic                   tick;
  logic [NUM_ENTRIES-1:0] dst_match, src_match, free_vec;
  logic                   dst_hit, src_hit, free_any, learn_we;
  logic [IDX_W-1:0]       dst_idx, src_idx, free_idx, learn_idx;

  function automatic logic [IDX_W:0] first_set(input logic [NUM_ENTRIES-1:0] v);
    first_set = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) first_set = {1'b1, IDX_W'(i)};
    end
  endfunction

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      dst_match[i] = entry_q[i].valid && (entry_q[i].mac == lookup_dst_i);
      src_match[i] = entry_q[i].valid && (entry_q[i].mac == learn_mac_i);
      free_vec[i]  = !entry_q[i].valid;
    end
  end

  assign {dst_hit, dst_idx}  = first_set(dst_match);
  assign {src_hit, src_idx}  = first_set(src_match);
  assign {free_any, free_idx} = first_set(free_vec);

  assign dst_hit_o  = dst_hit;
  assign dst_port_o = entry_q[dst_idx].port;

  // A hit refreshes in place (static entries are left alone); a miss claims the lowest free slot.
  assign learn_we     = learn_en_i && (src_hit ? !entry_q[src_idx].is_static : free_any);
  assign learn_idx    = src_hit ? src_idx : free_idx;
  assign learn_drop_o = learn_en_i && !src_hit && !free_any;
  assign table_full_o = table_full_q;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (tick && entry_q[i].valid && !entry_q[i].is_static) begin
        if (entry_q[i].age == '0) entry_d[i].valid = 1'b0;
        else                      entry_d[i].age   = entry_q[i].age - 1'b1;
      end
      if (learn_we && (learn_idx == IDX_W'(i))) begin
        entry_d[i] = '{valid: 1'b1, is_static: 1'b0, age: AGE_FULL,
                       port: learn_port_i, mac: learn_mac_i};
      end
      if (cfg_wr_en_i && (cfg_index_i == IDX_W'(i))) begin
        entry_d[i] = '{valid: cfg_valid_i, is_static: cfg_static_i, age: AGE_FULL,
                       port: cfg_port_i, mac: cfg_mac_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
      tick_cnt_q   <= '0;
      table_full_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= entry_d[i];
      tick_cnt_q   <= tick_cnt_d;
      table_full_q <= ~|free_vec;
    end
  end

endmodule

// File: rtl/mac_learning_port_lookup.sv
// rtl/mac_learning_port_lookup.sv - stream slice with learned/PTP/flood destination lookup
// Define LOOKUP_STATS_EN to add saturating hit/miss/learn-drop counters with stat_clr.
module mac_learning_port_lookup
  import mac_learning_port_lookup_pkg::*;
#(
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         SRC_PORT_POS         = 16,
  parameter int         DST_PORT_POS         = 24,
  parameter int         NUM_ENTRIES          = 32,
  parameter int         AGE_WIDTH            = 4,
  parameter int         AGE_TICK_CYCLES      = 1000000,
  parameter logic [7:0] FLOOD_MASK           = 8'h55
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              cfg_wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0]    cfg_index,
  input  logic [47:0]                       cfg_mac,
  input  logic [7:0]                        cfg_port,
  input  logic                              cfg_static,
  input  logic                              cfg_valid,
`ifdef LOOKUP_STATS_EN
  input  logic                              stat_clr,
  output logic [31:0]                       stat_hit,
  output logic [31:0]                       stat_miss,
  output logic [31:0]                       stat_learn_drop,
`endif
  output logic                              table_full
);

  logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata_q;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;
  logic                             tlast_q, tvalid_q, sop_q;

  logic        accept, is_ptp, lookup_hit, learn_en, learn_drop, use_flood;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic [7:0]  src_port, hit_port, dst_sel;

  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign dst_mac   = s_axis_tdata[47:0];
  assign src_mac   = s_axis_tdata[95:48];
  assign ethertype = s_axis_tdata[111:96];
  assign src_port  = s_axis_tuser[SRC_PORT_POS +: 8];
  assign is_ptp    = (dst_mac == PTP_DST_MAC) && (ethertype == PTP_ETHERTYPE);
  assign learn_en  = accept && sop_q && !src_mac[0] && (src_port != 8'h00);

  mac_table_cam #(
    .NUM_ENTRIES     (NUM_ENTRIES),
    .AGE_WIDTH       (AGE_WIDTH),
    .AGE_TICK_CYCLES (AGE_TICK_CYCLES)
  ) u_cam (
    .clk_i        (axis_aclk),
    .rst_ni       (axis_resetn),
    .lookup_dst_i (dst_mac),
    .dst_hit_o    (lookup_hit),
    .dst_port_o   (hit_port),
    .learn_en_i   (learn_en),
    .learn_mac_i  (src_mac),
    .learn_port_i (src_port),
    .cfg_wr_en_i  (cfg_wr_en),
    .cfg_index_i  (cfg_index),
    .cfg_mac_i    (cfg_mac),
    .cfg_port_i   (cfg_port),
    .cfg_static_i (cfg_static),
    .cfg_valid_i  (cfg_valid),
    .learn_drop_o (learn_drop),
    .table_full_o (table_full)
  );

  // Group destinations that are not PTP and unknown unicast both fall through to the flood rule.
  always_comb begin
    dst_sel   = FLOOD_MASK & ~src_port;
    use_flood = 1'b0;
    if (lookup_hit) begin
      dst_sel = hit_port;
    end else if (is_ptp) begin
      dst_sel = ((src_port & PORT_ODD_MASK) == 8'h00) ? PTP_CPU_PORT : {1'b0, src_port[7:1]};
    end else begin
      use_flood = 1'b1;
    end
    tuser_d = s_axis_tuser;
    if (sop_q) tuser_d[DST_PORT_POS +: 8] = dst_sel;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      sop_q    <= 1'b1;
    end else if (accept) begin
      tdata_q  <= s_axis_tdata;
      tkeep_q  <= s_axis_tkeep;
      tuser_q  <= tuser_d;
      tlast_q  <= s_axis_tlast;
      tvalid_q <= 1'b1;
      sop_q    <= s_axis_tlast;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = C_M_AXIS_DATA_WIDTH'(tdata_q);
  assign m_axis_tkeep  = (C_M_AXIS_DATA_WIDTH/8)'(tkeep_q);
  assign m_axis_tuser  = C_M_AXIS_TUSER_WIDTH'(tuser_q);
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

`ifdef LOOKUP_STATS_EN
  logic [31:0] stat_hit_q, stat_miss_q, stat_learn_drop_q;
  logic        sop_lookup;

  assign sop_lookup = accept && sop_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      stat_hit_q        <= '0;
      stat_miss_q       <= '0;
      stat_learn_drop_q <= '0;
    end else if (stat_clr) begin
      stat_hit_q        <= '0;
      stat_miss_q       <= '0;
      stat_learn_drop_q <= '0;
    end else begin
      if (sop_lookup && lookup_hit && (stat_hit_q != '1)) stat_hit_q <= stat_hit_q + 1'b1;
      if (sop_lookup && use_flood && (stat_miss_q != '1)) stat_miss_q <= stat_miss_q + 1'b1;
      if (learn_drop && (stat_learn_drop_q != '1))        stat_learn_drop_q <= stat_learn_drop_q + 1'b1;
    end
  end

  assign stat_hit        = stat_hit_q;
  assign stat_miss       = stat_miss_q;
  assign stat_learn_drop = stat_learn_drop_q;
`else
  logic unused_stats;
  assign unused_stats = learn_drop ^ use_flood;
`endif

endmodule

// File: tb/tb_mac_learning_port_lookup.sv
// tb/tb_mac_learning_port_lookup.sv - scoreboard bench for mac_learning_port_lookup
// Stimulus pushes expected beats; a negedge monitor pops and compares on each output handshake.
module tb_mac_learning_port_lookup;

  logic         axis_aclk = 1'b0;
  logic         axis_resetn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         cfg_wr_en, cfg_static, cfg_valid;
  logic [4:0]   cfg_index;
  logic [47:0]  cfg_mac;
  logic [7:0]   cfg_port;
  logic         table_full;

  typedef struct {
    logic [255:0] data;
    logic [127:0] user;
    logic         last;
    int           id;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_sent = 0;

  always #5 axis_aclk = ~axis_aclk;

  mac_learning_port_lookup #(.AGE_TICK_CYCLES(8)) dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_index     (cfg_index),
    .cfg_mac       (cfg_mac),
    .cfg_port      (cfg_port),
    .cfg_static    (cfg_static),
    .cfg_valid     (cfg_valid),
    .table_full    (table_full)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [47:0] sw(input logic [47:0] m);
    return {m[7:0], m[15:8], m[23:16], m[31:24], m[39:32], m[47:40]};
  endfunction

  function automatic logic [255:0] frm(input logic [47:0] dst, input logic [47:0] src,
                                       input logic [15:0] et, input logic [7:0] tag);
    logic [255:0] d;
    d = {16{tag, 8'h5A}};
    d[47:0]   = sw(dst);
    d[95:48]  = sw(src);
    d[111:96] = {et[7:0], et[15:8]};
    return d;
  endfunction

  function automatic logic [127:0] usr(input logic [7:0] sp, input logic [7:0] df);
    logic [127:0] u;
    u = {8{16'hBEEF}};
    u[23:16] = sp;
    u[31:24] = df;
    return u;
  endfunction

  task automatic send(input logic [255:0] d, input logic [127:0] u, input logic last,
                      input logic [127:0] exp_u);
    int w = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge axis_aclk);
    while (!s_axis_tready && w < 50) begin
      @(negedge axis_aclk);
      w++;
    end
    if (!s_axis_tready) chk("send_ready_timeout", s_axis_tready, 1);
    else q.push_back('{d, exp_u, last, n_sent++});
    @(posedge axis_aclk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      @(posedge axis_aclk);
      w++;
    end
    #1;
  endtask

  task automatic reset_dut();
    axis_resetn = 1'b0;
    repeat (2) @(posedge axis_aclk);
    #1 axis_resetn = 1'b1;
  endtask

  task automatic cfg_write(input logic [4:0] idx, input logic [47:0] mac, input logic [7:0] port,
                           input logic st, input logic vld);
    cfg_index = idx; cfg_mac = mac; cfg_port = port; cfg_static = st; cfg_valid = vld;
    cfg_wr_en = 1'b1;
    @(posedge axis_aclk);
    #1 cfg_wr_en = 1'b0;
  endtask

  always @(negedge axis_aclk) begin
    if (axis_resetn && m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", m_axis_tuser, '1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("beat%0d_tuser", e.id), m_axis_tuser, e.user);
        chk($sformatf("beat%0d_data_last", e.id), {m_axis_tlast, m_axis_tdata[254:0]},
            {e.last, e.data[254:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] ptp, bc, s_mac;
    ptp = 48'h0180C200000E;
    bc  = 48'hFFFFFFFFFFFF;
    s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tkeep = '1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    cfg_wr_en = 1'b0; cfg_index = '0; cfg_mac = '0; cfg_port = '0; cfg_static = 1'b0; cfg_valid = 1'b0;
    axis_resetn = 1'b0;
    repeat (3) @(posedge axis_aclk);
    #1 axis_resetn = 1'b1;

    @(negedge axis_aclk);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_table_full", table_full, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_m_tuser", m_axis_tuser, 0);
    @(posedge axis_aclk);
    #1;

    // Miss flood, learn, reverse hit, continuation beat, invalidate index 0
    send(frm(48'h112233445566, 48'h020000000001, 16'h0800, 8'h01), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h54));
    send(frm(48'h020000000001, 48'h020000000004, 16'h0800, 8'h02), usr(8'h04, 8'h00), 0, usr(8'h04, 8'h01));
    send(frm(48'h0, 48'h0, 16'h0, 8'h03), usr(8'h04, 8'h77), 1, usr(8'h04, 8'h77));
    cfg_write(5'd0, 48'h0, 8'h00, 1'b0, 1'b0);
    send(frm(48'h020000000001, 48'h020000000004, 16'h0800, 8'h04), usr(8'h04, 8'h00), 1, usr(8'h04, 8'h51));

    // PTP steering
    send(frm(ptp, 48'h020000000022, 16'h88F7, 8'h05), usr(8'h02, 8'h00), 1, usr(8'h02, 8'h01));
    send(frm(ptp, 48'h020000000011, 16'h88F7, 8'h06), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h02));
    send(frm(ptp, 48'h020000000088, 16'h88F7, 8'h07), usr(8'h08, 8'h00), 1, usr(8'h08, 8'h04));
    send(frm(ptp, 48'h020000000011, 16'h0800, 8'h08), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h54));

    // Reset in the middle of a packet; next beat must be treated as sop
    send(frm(48'h112233445566, 48'h020000000033, 16'h0800, 8'h09), usr(8'h01, 8'h00), 0, usr(8'h01, 8'h54));
    wait_drain();
    reset_dut();

    // Static entry survives learning and aging
    s_mac = 48'h020000000099;
    cfg_write(5'd3, sw(s_mac), 8'h10, 1'b1, 1'b1);
    send(frm(bc, s_mac, 16'h0800, 8'h0A), usr(8'h04, 8'hEE), 1, usr(8'h04, 8'h51));
    send(frm(s_mac, 48'h020000000011, 16'h0800, 8'h0B), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h10));
    wait_drain();
    repeat (140) @(posedge axis_aclk);
    #1;
    send(frm(s_mac, 48'h020000000011, 16'h0800, 8'h0C), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h10));
    wait_drain();

    // Fill the table, overflow, then age everything out
    reset_dut();
    for (int k = 0; k < 32; k++)
      send(frm(bc, 48'h020000000100 + 48'(k), 16'h0800, 8'(k)), usr(8'h04, 8'h00), 1, usr(8'h04, 8'h51));
    repeat (2) @(posedge axis_aclk);
    @(negedge axis_aclk);
    chk("table_full_after_32", table_full, 1);
    @(posedge axis_aclk);
    #1;
    send(frm(bc, 48'h020000000200, 16'h0800, 8'h20), usr(8'h04, 8'h00), 1, usr(8'h04, 8'h51));
    send(frm(48'h020000000200, 48'h020000000011, 16'h0800, 8'h21), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h54));
    send(frm(48'h020000000105, 48'h020000000011, 16'h0800, 8'h22), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h04));
    wait_drain();
    repeat (140) @(posedge axis_aclk);
    @(negedge axis_aclk);
    chk("table_full_after_aging", table_full, 0);
    @(posedge axis_aclk);
    #1;
    send(frm(48'h020000000105, 48'h020000000011, 16'h0800, 8'h23), usr(8'h01, 8'h00), 1, usr(8'h01, 8'h54));

    // Downstream stall in the middle of a packet
    send(frm(bc, 48'h020000000011, 16'h0800, 8'h30), usr(8'h01, 8'h00), 0, usr(8'h01, 8'h54));
    m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge axis_aclk);
      chk("stall_s_tready", s_axis_tready, 0);
      chk("stall_m_tvalid", m_axis_tvalid, 1);
      chk("stall_m_tuser", m_axis_tuser, usr(8'h01, 8'h54));
    end
    @(posedge axis_aclk);
    #1 m_axis_tready = 1'b1;
    send(frm(48'h0, 48'h0, 16'h0, 8'hB1), usr(8'h01, 8'h33), 0, usr(8'h01, 8'h33));
    send(frm(48'h0, 48'h0, 16'h0, 8'hB2), usr(8'h01, 8'h44), 1, usr(8'h01, 8'h44));

    wait_drain();
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_learning_port_lookup.md
Name: mac_learning_port_lookup

Overview:
- Parametrised successor to the static 32-entry output port lookup.
- Sits between the RX input arbiter and the output queues on the AXI-Stream datapath.
- Adds a hardware MAC learning table with aging, CPU-writable static entries, miss flooding and a registered one-cycle output slice.
- Keeps PTP (01:80:C2:00:00:0E, EtherType 0x88F7) steering.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (≥128).
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal master.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width.
- SRC_PORT_POS, 16, LSB of the 8-bit one-hot source-port field in tuser.
- DST_PORT_POS, 24, LSB of the 8-bit destination-port mask in tuser.
- NUM_ENTRIES, 32, table depth; power of two, 4..256.
- AGE_WIDTH, 4, per-entry age counter width.
- AGE_TICK_CYCLES, 1000000, axis_aclk cycles per aging tick.
- FLOOD_MASK, 8'h55, port mask used on miss/broadcast before the source port is removed.

Ports:
- axis_aclk  in  1  clock
- axis_resetn  in  1  asynchronous active-low reset
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per params  slave stream
- s_axis_tready  out  1  slave ready
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per params  master stream
- m_axis_tready  in  1  master ready
- cfg_wr_en  in  1  one-cycle table write strobe
- cfg_index  in  $clog2(NUM_ENTRIES)  entry written
- cfg_mac  in  48  MAC, byte-swapped as it appears in tdata[47:0]
- cfg_port  in  8  port mask
- cfg_static  in  1  1 = never ages, never overwritten by learning
- cfg_valid  in  1  0 = invalidate entry
- table_full  out  1  no free entry; registered

Behaviour:
- Reset: all entries invalid, m_axis_tvalid=0, output regs 0, table_full=0, tick counter 0, sop=1.
- sop flag: set by reset and by an accepted tlast beat; cleared by any other accepted beat.
- Output slice: one register stage, latency 1 cycle. s_axis_tready = !m_axis_tvalid || m_axis_tready.
- Beat acceptance: beat accepted when s_axis_tvalid && s_axis_tready. On each accepted beat, tdata/tkeep/tlast/tuser are registered.
- Destination lookup (accepted sop beats only): DST_PORT field overwritten, first matching rule wins:
  1. Valid entry with mac == dst; lowest index wins; output that entry's port.
  2. PTP dst+type and (src & 8'hAA)==0 → 8'h02.
  3. PTP dst+type and (src & 8'hAA)!=0 → {1'b0, src[7:1]}.
  4. dst[0] (group bit) set, or miss → FLOOD_MASK & ~src.
  5. Result 0 is legal; the queue drops it.
- Non-sop beats: pass the tuser field through unchanged.
- Learning (accepted sop beat, src MAC not group, src field nonzero):
  - Hit on a non-static entry: refresh age to all-ones and update its port.
  - Hit on a static entry: no change.
  - Miss: write lowest-index invalid entry with age all-ones.
  - Miss with table full: no learn, table_full stays 1.
  - All updates are visible to the lookup on the following cycle. Same-cycle self-forwarding is not required.
- Aging: tick counter wraps at AGE_TICK_CYCLES-1. On wrap, every valid non-static entry decrements its age; an entry already at 0 becomes invalid.
- Collisions, same cycle:
  - cfg_wr_en beats learning on any index. A learn aimed at the same index is dropped, not retried.
  - Learn refresh beats the aging decrement for that entry.
- table_full: recomputed every cycle from registered valid bits.
- Reset mid-packet: stream state and table are cleared; the next beat is treated as sop.

Optional Feature:
- LOOKUP_STATS_EN defined: adds outputs stat_hit, stat_miss, stat_learn_drop, each 32-bit, saturating.
  - Incremented per sop lookup hit, per miss/flood, and per full-table learn failure.
  - Cleared by reset or by a one-cycle input stat_clr.
- LOOKUP_STATS_EN undefined: these ports and their logic are absent.

Decomposition:
- Shared package: PTP_DST_MAC, PTP_ETHERTYPE, PTP_CPU_PORT (8'h02), PORT_ODD_MASK (8'hAA), and the entry struct {valid, static, age, port, mac}.
- One sub-module, mac_table_cam: storage, parallel match, priority encoders (match, free), aging and write arbitration. The top level holds the stream slice, sop tracking and rule selection.

Test Plan:
- Empty table; sop dst=11:22:33:44:55:66, src port 8'h01 → m_axis tuser dst=8'h54 on cycle +1; src MAC learned at index 0 with port 8'h01.
- Reverse frame to the learned MAC from port 8'h04 → dst=8'h01; second beat with tlast carries tuser unchanged.
- PTP frame from port 8'h02 → dst 8'h01. PTP frame from port 8'h01 → dst 8'h02.
- cfg static entry idx 3 → port 8'h10; learn the same MAC from port 8'h04 → entry unchanged, lookup returns 8'h10; 16 aging ticks → entry survives.
- Learn 32 distinct MACs → table_full=1; 33rd frame is not learned; AGE_TICK_CYCLES=8 with 16 ticks → all entries age out, table_full=0.
- m_axis_tready low for 5 cycles mid-packet → s_axis_tready=0 and output held stable; no beat lost or duplicated.
